// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port (AD3/WE3/WD3) between two writers:
//   the in-order pipeline writeback and a long-latency unit that uses valid/ready.
//   The pipeline normally wins the port. After STARVE_LIMIT consecutive cycles in
//   which the long-latency unit is refused, it is promoted and wins the next grant.
//   A busy scoreboard marks registers that still wait for a long-latency result, so
//   decode can stall on RAW (hazard) and WAW (issue_stall) dependencies.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_wd         pipeline writeback request
//   pipe_stall                      pipeline write not granted; hold and retry
//   lu_valid/lu_rd/lu_wd, lu_ready  long-latency result handshake
//   issue_valid/issue_rd            long-latency dispatch; issue_stall on WAW
//   rs1/rs2, hazard                 decode sources; pending long-latency write
//   AD3/WE3/WD3                     register file write port
module regfile_write_arbiter #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pipe_we,
  input  logic [ADDR_WIDTH-1:0] pipe_rd,
  input  logic [DATA_WIDTH-1:0] pipe_wd,
  output logic                  pipe_stall,
  input  logic                  lu_valid,
  input  logic [ADDR_WIDTH-1:0] lu_rd,
  input  logic [DATA_WIDTH-1:0] lu_wd,
  output logic                  lu_ready,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_stall,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  hazard,
  output logic [ADDR_WIDTH-1:0] AD3,
  output logic                  WE3,
  output logic [DATA_WIDTH-1:0] WD3
);

  localparam int         NREG  = 1 << ADDR_WIDTH;
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {
    PIPE_PRI,
    LU_PRI
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [3:0]      cnt_inc;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;

  logic preq;
  logic lreq;
  logic conflict;
  logic lu_grant;
  logic pipe_grant;
  logic issue_set;

  // Writes to x0 are discarded, so they never compete for the port.
  assign preq     = pipe_we && (pipe_rd != '0);
  assign lreq     = lu_valid && (lu_rd != '0);
  assign conflict = preq && lreq;

  assign lu_grant   = lreq && ((state == LU_PRI) || !preq);
  assign pipe_grant = preq && !lu_grant;

  // Outputs are qualified by rst_n so they read 0 the moment reset asserts,
  // not only after the next clock edge.
  assign pipe_stall  = rst_n && preq && !pipe_grant;
  assign lu_ready    = rst_n && lu_valid && (lu_grant || (lu_rd == '0));
  assign hazard      = rst_n && (busy[rs1] || busy[rs2]);
  assign issue_stall = rst_n && busy[issue_rd];

  assign issue_set = issue_valid && (issue_rd != '0) && !busy[issue_rd];
  assign cnt_inc   = (cnt == 4'hF) ? cnt : cnt + 4'd1;

  // Write-port mux.
  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    WE3 = 1'b0;
    AD3 = '0;
    WD3 = '0;
    if (rst_n) begin
      if (lu_grant) begin
        WE3 = 1'b1;
        AD3 = lu_rd;
        WD3 = lu_wd;
      end else if (pipe_grant) begin
        WE3 = 1'b1;
        AD3 = pipe_rd;
        WD3 = pipe_wd;
      end
    end
  end

  // Scoreboard update: the clear is applied before the set so a same-cycle
  // set to the same register wins.
  always_comb begin
    busy_next = busy;
    if (lu_ready) busy_next[lu_rd] = 1'b0;
    if (issue_set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Priority FSM with starvation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= PIPE_PRI;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      case (state)
        PIPE_PRI: begin
          if (!lu_valid || lu_ready) begin
            cnt <= '0;
          end else if (conflict) begin
            cnt <= cnt_inc;
            if (cnt_inc >= LIMIT) state <= LU_PRI;
          end
        end
        LU_PRI: begin
          // Leave on the handshake, or if the requester withdrew lu_valid.
          if (lu_ready || !lu_valid) begin
            state <= PIPE_PRI;
            cnt   <= '0;
          end
        end
        default: begin
          state <= PIPE_PRI;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: busy is a flop vector, not a RAM, so it is cleared by reset; a
    // pending long-latency result is dropped and must be re-presented.
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. Inputs are driven 1 ns after
// the rising edge and outputs are compared 1 ns later against a behavioural
// model of the sharing rules (priority flag, denied-streak count, busy set).
module tb_regfile_write_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  typedef logic [AW+DW+5:0] ovec_t;  // {WE3, AD3, WD3, pipe_stall, lu_ready, issue_stall, hazard}

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pipe_we, lu_valid, issue_valid;
  logic [AW-1:0] pipe_rd, lu_rd, issue_rd, rs1, rs2;
  logic [DW-1:0] pipe_wd, lu_wd;
  logic          pipe_stall, lu_ready, issue_stall, hazard, WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;

  int errors = 0;
  int checks = 0;

  regfile_write_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs1(rs1), .rs2(rs2), .hazard(hazard),
    .AD3(AD3), .WE3(WE3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit    mdl_busy [32];
  bit    mdl_promoted;
  int    mdl_denied;
  bit    mdl_conflict;
  bit    exp_hs, exp_ps, exp_is;
  ovec_t exp_o;

  function automatic ovec_t observed();
    return {WE3, AD3, WD3, pipe_stall, lu_ready, issue_stall, hazard};
  endfunction

  task automatic model_reset();
    foreach (mdl_busy[i]) mdl_busy[i] = 1'b0;
    mdl_promoted = 1'b0;
    mdl_denied   = 0;
  endtask

  task automatic model_eval();
    bit preq, lreq, lu_win, pipe_win, e_we, e_lr, e_hz;
    logic [AW-1:0] e_ad;
    logic [DW-1:0] e_wd;
    preq     = pipe_we && (pipe_rd != 0);
    lreq     = lu_valid && (lu_rd != 0);
    lu_win   = lreq && (mdl_promoted || !preq);
    pipe_win = preq && !lu_win;
    e_we     = lu_win || pipe_win;
    e_ad     = lu_win ? lu_rd : (pipe_win ? pipe_rd : '0);
    e_wd     = lu_win ? lu_wd : (pipe_win ? pipe_wd : '0);
    exp_ps   = preq && !pipe_win;
    e_lr     = lu_valid && (lu_win || lu_rd == 0);
    exp_is   = mdl_busy[issue_rd];
    e_hz     = mdl_busy[rs1] || mdl_busy[rs2];
    exp_hs   = e_lr;
    mdl_conflict = preq && lreq;
    exp_o = {e_we, e_ad, e_wd, exp_ps, e_lr, exp_is, e_hz};
    if (!rst_n) begin
      exp_o  = '0;
      exp_hs = 1'b0;
      exp_ps = 1'b0;
      exp_is = 1'b0;
    end
  endtask

  task automatic model_commit();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (mdl_promoted) begin
      if (exp_hs || !lu_valid) begin
        mdl_promoted = 1'b0;
        mdl_denied   = 0;
      end
    end else if (!lu_valid || exp_hs) begin
      mdl_denied = 0;
    end else if (mdl_conflict) begin
      mdl_denied = (mdl_denied < 15) ? mdl_denied + 1 : 15;
      if (mdl_denied >= LIMIT) mdl_promoted = 1'b1;
    end
    if (exp_hs) mdl_busy[lu_rd] = 1'b0;
    if (issue_valid && issue_rd != 0 && !exp_is) mdl_busy[issue_rd] = 1'b1;
  endtask

  // Advance one clock; inputs may be changed right after return.
  task automatic tick();
    model_eval();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    pipe_we = 0; pipe_rd = '0; pipe_wd = '0;
    lu_valid = 0; lu_rd = '0; lu_wd = '0;
    issue_valid = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    model_reset();
    pipe_we = 1; pipe_rd = 7; pipe_wd = 32'h1234_5678;
    lu_valid = 1; lu_rd = 9; lu_wd = 32'hCAFE_0001;
    issue_valid = 1; issue_rd = 3; rs1 = 3;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", observed(), ovec_t'(0));
    end
    tick();
    drive_idle();
    rst_n = 1;
    #1;
    model_eval();
    checks++;
    if (observed() !== exp_o) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", observed(), exp_o);
    end
    tick();
  endtask

  task automatic test_pipe_only();
    drive_idle();
    pipe_we = 1; pipe_rd = 7; pipe_wd = 32'hDEAD_BEEF;
    #1;
    model_eval();
    checks++;
    if (observed() !== exp_o) begin
      errors++;
      $display("FAIL pipe_only_model: got %h expected %h", observed(), exp_o);
    end
    checks++;
    if (!(WE3 === 1'b1 && AD3 === 5'd7 && WD3 === 32'hDEAD_BEEF && pipe_stall === 1'b0)) begin
      errors++;
      $display("FAIL pipe_only_port: got we=%b ad=%0d wd=%h stall=%b expected we=1 ad=7 wd=deadbeef stall=0",
               WE3, AD3, WD3, pipe_stall);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_starvation();
    logic [AW-1:0] want_ad;
    drive_idle();
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'hAAAA_0003;
    lu_valid = 1; lu_rd = 9; lu_wd = 32'hBBBB_0009;
    for (int c = 0; c < 6; c++) begin
      #1;
      model_eval();
      checks++;
      if (observed() !== exp_o) begin
        errors++;
        $display("FAIL starve_model cycle %0d: got %h expected %h", c, observed(), exp_o);
      end
      want_ad = (c == LIMIT) ? 5'd9 : 5'd3;
      checks++;
      if (AD3 !== want_ad || lu_ready !== (c == LIMIT) || pipe_stall !== (c == LIMIT)) begin
        errors++;
        $display("FAIL starve_grant cycle %0d: got ad=%0d ready=%b stall=%b expected ad=%0d ready=%b stall=%b",
                 c, AD3, lu_ready, pipe_stall, want_ad, c == LIMIT, c == LIMIT);
      end
      tick();
    end
    drive_idle();
    tick();
  endtask

  task automatic test_scoreboard();
    drive_idle();
    issue_valid = 1; issue_rd = 12;
    #1;
    model_eval();
    checks++;
    if (observed() !== exp_o || issue_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_issue: got %h expected %h", observed(), exp_o);
    end
    tick();
    issue_valid = 0; rs1 = 12; rs2 = 0;
    #1;
    model_eval();
    checks++;
    if (hazard !== 1'b1 || observed() !== exp_o) begin
      errors++;
      $display("FAIL sb_raw_hazard: got hazard=%b expected 1", hazard);
    end
    tick();
    issue_valid = 1; issue_rd = 12;
    #1;
    model_eval();
    checks++;
    if (issue_stall !== 1'b1 || observed() !== exp_o) begin
      errors++;
      $display("FAIL sb_waw_stall: got issue_stall=%b expected 1", issue_stall);
    end
    tick();
    issue_valid = 0; lu_valid = 1; lu_rd = 12; lu_wd = 32'h0000_0C0C;
    #1;
    model_eval();
    checks++;
    if (hazard !== 1'b1 || lu_ready !== 1'b1 || observed() !== exp_o) begin
      errors++;
      $display("FAIL sb_hs_cycle: got hazard=%b ready=%b expected hazard=1 ready=1", hazard, lu_ready);
    end
    tick();
    lu_valid = 0;
    #1;
    model_eval();
    checks++;
    if (hazard !== 1'b0 || observed() !== exp_o) begin
      errors++;
      $display("FAIL sb_after_hs: got hazard=%b expected 0", hazard);
    end
    tick();
  endtask

  task automatic test_set_clear();
    drive_idle();
    lu_valid = 1; lu_rd = 5; lu_wd = 32'h5555_5555;
    issue_valid = 1; issue_rd = 5;
    #1;
    model_eval();
    checks++;
    if (lu_ready !== 1'b1 || observed() !== exp_o) begin
      errors++;
      $display("FAIL setclr_cycle: got %h expected %h", observed(), exp_o);
    end
    tick();
    drive_idle();
    rs2 = 5; issue_valid = 1; issue_rd = 5;
    #1;
    model_eval();
    checks++;
    if (hazard !== 1'b1 || issue_stall !== 1'b1) begin
      errors++;
      $display("FAIL setclr_set_wins: got hazard=%b issue_stall=%b expected 1 1", hazard, issue_stall);
    end
    issue_valid = 0;
    // Retire r5 so later tests start from a clean scoreboard.
    lu_valid = 1; lu_rd = 5;
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_x0();
    drive_idle();
    lu_valid = 1; lu_rd = 0; lu_wd = 32'hFFFF_FFFF;
    pipe_we = 1; pipe_rd = 4; pipe_wd = 32'h0000_0444;
    issue_valid = 1; issue_rd = 0;
    #1;
    model_eval();
    checks++;
    if (!(lu_ready === 1'b1 && WE3 === 1'b1 && AD3 === 5'd4 && WD3 === 32'h0000_0444 && pipe_stall === 1'b0)) begin
      errors++;
      $display("FAIL x0_lu_accept: got ready=%b we=%b ad=%0d wd=%h stall=%b expected 1 1 4 00000444 0",
               lu_ready, WE3, AD3, WD3, pipe_stall);
    end
    tick();
    drive_idle();
    pipe_we = 1; pipe_rd = 0; pipe_wd = 32'h7777_7777;
    #1;
    model_eval();
    checks++;
    if (WE3 !== 1'b0 || AD3 !== '0 || WD3 !== '0 || hazard !== 1'b0 || pipe_stall !== 1'b0) begin
      errors++;
      $display("FAIL x0_pipe_discard: got we=%b ad=%0d wd=%h hazard=%b expected 0 0 0 0", WE3, AD3, WD3, hazard);
    end
    tick();
    drive_idle();
  endtask

  task automatic test_reset_mid();
    drive_idle();
    issue_valid = 1; issue_rd = 5;
    tick();
    issue_rd = 12;
    tick();
    issue_valid = 0;
    pipe_we = 1; pipe_rd = 3; pipe_wd = 32'h3333_3333;
    lu_valid = 1; lu_rd = 9; lu_wd = 32'h9999_9999;
    rs1 = 5; rs2 = 12;
    for (int c = 0; c < LIMIT; c++) tick();
    #1;
    model_eval();
    checks++;
    if (AD3 !== 5'd9 || hazard !== 1'b1 || observed() !== exp_o) begin
      errors++;
      $display("FAIL midrst_pre: got %h expected %h", observed(), exp_o);
    end
    rst_n = 0;
    #1;
    checks++;
    if (observed() !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h expected %h", observed(), ovec_t'(0));
    end
    tick();
    rst_n = 1;
    #1;
    model_eval();
    checks++;
    if (AD3 !== 5'd3 || lu_ready !== 1'b0 || hazard !== 1'b0 || observed() !== exp_o) begin
      errors++;
      $display("FAIL midrst_after: got ad=%0d ready=%b hazard=%b expected ad=3 ready=0 hazard=0",
               AD3, lu_ready, hazard);
    end
    tick();
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    bit lu_hold = 0;
    bit pipe_hold = 0;
    drive_idle();
    for (int c = 0; c < 500; c++) begin
      if (!lu_hold) begin
        lu_valid = ($urandom_range(0, 1) == 1);
        lu_rd    = AW'($urandom_range(0, 7));
        lu_wd    = $urandom;
      end
      if (!pipe_hold) begin
        pipe_we = ($urandom_range(0, 2) != 0);
        pipe_rd = AW'($urandom_range(0, 7));
        pipe_wd = $urandom;
      end
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, 7));
      rs1         = AW'($urandom_range(0, 7));
      rs2         = AW'($urandom_range(0, 7));
      #1;
      model_eval();
      checks++;
      if (observed() !== exp_o) begin
        errors++;
        $display("FAIL random cycle %0d: got %h expected %h", c, observed(), exp_o);
      end
      lu_hold   = lu_valid && !exp_hs;
      pipe_hold = exp_ps;
      tick();
    end
    drive_idle();
    tick();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_pipe_only();
    test_starvation();
    test_scoreboard();
    test_set_clear();
    test_x0();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (AD3/WE3/WD3) between two writers:
  - the in-order pipeline writeback;
  - a long-latency unit (load/multi-cycle result) using a valid/ready handshake.
- Keeps a 32-entry busy scoreboard of registers with outstanding long-latency results, so decode can stall RAW and WAW hazards.
- Sits between writeback/long-latency unit and register_file write inputs; hazard outputs feed the stall logic.

Parameters:
- ADDR_WIDTH, 5, register address width (32 registers).
- DATA_WIDTH, 32, write data width.
- STARVE_LIMIT, 4, consecutive denied cycles before the long-latency unit is promoted to priority (legal range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pipe_we  in  1  pipeline writeback request.
- pipe_rd  in  ADDR_WIDTH  pipeline destination register.
- pipe_wd  in  DATA_WIDTH  pipeline write data.
- pipe_stall  out  1  pipeline writeback not granted this cycle; hold and retry.
- lu_valid  in  1  long-latency result valid.
- lu_rd  in  ADDR_WIDTH  long-latency destination register.
- lu_wd  in  DATA_WIDTH  long-latency write data.
- lu_ready  out  1  long-latency result accepted this cycle.
- issue_valid  in  1  long-latency op dispatched this cycle.
- issue_rd  in  ADDR_WIDTH  its destination register.
- issue_stall  out  1  busy[issue_rd] set (WAW); dispatch must wait.
- rs1  in  ADDR_WIDTH  decode source 1.
- rs2  in  ADDR_WIDTH  decode source 2.
- hazard  out  1  rs1 or rs2 has a pending long-latency write.
- AD3  out  ADDR_WIDTH  register file write address.
- WE3  out  1  register file write enable.
- WD3  out  DATA_WIDTH  register file write data.

Behaviour:
- Request qualification:
  - preq = pipe_we && pipe_rd != 0.
  - lreq = lu_valid && lu_rd != 0.
  - lu_valid with lu_rd == 0 is accepted immediately (lu_ready=1), never drives WE3, and does not count as a port conflict.
- States: PIPE_PRI (reset), LU_PRI. Starvation counter cnt, 4 bits, saturating.
- PIPE_PRI:
  - preq wins whenever present.
  - lreq alone is granted.
  - On conflict (preq && lreq): lu_ready=0 and cnt increments.
  - When cnt reaches STARVE_LIMIT, the state becomes LU_PRI at the next edge.
  - cnt clears on any lu handshake, or whenever lu_valid is low.
- LU_PRI:
  - lreq granted; pipe_stall=1 if preq.
  - On the lu handshake edge: return to PIPE_PRI, cnt=0.
  - If lu_valid drops without a handshake (protocol violation), return to PIPE_PRI.
- Grant output is combinational in the same cycle:
  - WE3=1, AD3/WD3 = granted rd/wd.
  - With no grant: WE3=0, AD3=0, WD3=0.
  - pipe_stall = preq && !pipe_grant.
  - lu_ready = lu_valid && (lu_grant || lu_rd == 0).
- Handshake rule: lu_valid, lu_rd and lu_wd are held stable until lu_ready. The pipeline holds pipe_* while pipe_stall=1.
- Scoreboard busy[31:0], registered:
  - issue_valid && issue_rd != 0 && !issue_stall sets busy[issue_rd].
  - lu handshake clears busy[lu_rd].
  - Set and clear of the same index in one cycle: set wins.
  - busy[0] is constantly 0.
- Hazard outputs, combinational from registered busy, with no bypass:
  - hazard = busy[rs1] || busy[rs2]. x0 never hazards.
  - hazard stays 1 in the handshake cycle and drops the cycle after, when the register file already holds the value.
  - issue_stall = busy[issue_rd].
- Reset while rst_n=0:
  - busy=0, state=PIPE_PRI, cnt=0.
  - All outputs forced to 0: WE3, lu_ready, pipe_stall, hazard, issue_stall.
- Reset mid-handshake: the pending lu result is dropped, and the requester must re-present it after reset.

Test Plan:
- pipe_we=1, pipe_rd=7, pipe_wd=0xDEADBEEF, lu idle -> same cycle WE3=1, AD3=7, WD3=0xDEADBEEF, pipe_stall=0.
- Conflict: preq (rd=3) and lreq (rd=9) held every cycle, STARVE_LIMIT=4 -> pipe granted cycles 0-3; cycle 4 LU_PRI: AD3=9, lu_ready=1, pipe_stall=1; cycle 5 pipe granted again.
- issue_valid, issue_rd=12; next cycle rs1=12 -> hazard=1. lu handshake for rd 12 -> hazard=1 that cycle, 0 next cycle. A second issue to 12 while busy -> issue_stall=1.
- Same-cycle lu handshake clearing rd 5 and issue to rd 5 -> busy[5] remains 1.
- lu_valid=1, lu_rd=0 with pipe_we=1, rd=4 -> lu_ready=1, WE3=1, AD3=4, no stall. pipe_rd=0 -> WE3=0. rs1=rs2=0 -> hazard=0.
- Assert rst_n low mid-conflict (in LU_PRI, busy=0x0000_1020) -> all outputs 0 immediately; after release busy=0, PIPE_PRI, first conflict grants pipe.
